// File: rtl/spi_flash_cmd_engine.sv
// SPI mode-0 command engine for the serial PROM: one start sends an opcode, an optional
// address, then clocks in 0..MAX_RD_BYTES response bytes under cs_prom_n.
module spi_flash_cmd_engine #(
  parameter int CLK_DIV      = 2,
  parameter int ADDR_BYTES   = 3,
  parameter int MAX_RD_BYTES = 4,
  parameter int CS_SETUP     = 2,
  parameter int CS_HOLD      = 2
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic [7:0]                        opcode,
  input  logic                              addr_en,
  input  logic [8*ADDR_BYTES-1:0]           addr,
  input  logic [$clog2(MAX_RD_BYTES+1)-1:0] rd_len,
  output logic                              busy,
  output logic                              done,
  output logic [8*MAX_RD_BYTES-1:0]         rd_data,
  output logic                              SPICLK,
  output logic                              SPIMOSI,
  input  logic                              SPIMISO,
  output logic                              cs_prom_n,
  output logic [2:0]                        state_dbg
);

  // Handshake: start is a one-cycle request honoured only in IDLE; busy is high from the
  // cycle after acceptance until the done cycle; done pulses once with busy low and rd_data
  // valid, and rd_data then holds until the next accepted start.

  localparam int LEN_W    = $clog2(MAX_RD_BYTES + 1);
  localparam int ADDR_W   = 8 * ADDR_BYTES;
  localparam int RD_W     = 8 * MAX_RD_BYTES;
  localparam int TX_W     = 8 + ADDR_W;
  localparam int HC_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WAIT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int WC_W     = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam int CNT_W    = (LEN_W > 3) ? LEN_W : 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_CMD   = 3'd2,
    ST_ADDR  = 3'd3,
    ST_READ  = 3'd4,
    ST_HOLD  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [HC_W-1:0]   hcnt_q, hcnt_d;
  logic [WC_W-1:0]   wait_q, wait_d;
  logic [2:0]        bit_q, bit_d;
  logic [CNT_W-1:0]  byte_q, byte_d;
  logic [TX_W-1:0]   tx_q, tx_d;
  logic [RD_W-1:0]   rx_q, rx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              addr_en_q, addr_en_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;

  logic [LEN_W-1:0]  len_clamped;
  logic              last_byte;
  state_t            next_phase;

  assign len_clamped = (rd_len > LEN_W'(MAX_RD_BYTES)) ? LEN_W'(MAX_RD_BYTES) : rd_len;

  // Where the current phase ends and which phase follows it.
  always_comb begin
    last_byte  = 1'b1;
    next_phase = ST_HOLD;
    case (state_q)
      ST_CMD: begin
        if (addr_en_q) begin
          next_phase = ST_ADDR;
        end else if (len_q != '0) begin
          next_phase = ST_READ;
        end
      end
      ST_ADDR: begin
        last_byte = (byte_q == CNT_W'(ADDR_BYTES - 1));
        if (len_q != '0) begin
          next_phase = ST_READ;
        end
      end
      ST_READ: begin
        last_byte = (byte_q == (CNT_W'(len_q) - CNT_W'(1)));
      end
      default: begin
        last_byte = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    wait_d    = wait_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    len_d     = len_q;
    addr_en_d = addr_en_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SETUP;
          tx_d      = {opcode, addr & {ADDR_W{addr_en}}};
          mosi_d    = opcode[7];
          rx_d      = '0;
          len_d     = len_clamped;
          addr_en_d = addr_en;
          hcnt_d    = '0;
          wait_d    = '0;
          bit_d     = '0;
          byte_d    = '0;
          sclk_d    = 1'b0;
        end
      end
      ST_SETUP: begin
        if (wait_q == WC_W'(CS_SETUP - 1)) begin
          wait_d  = '0;
          state_d = ST_CMD;
        end else begin
          wait_d = wait_q + WC_W'(1);
        end
      end
      ST_CMD, ST_ADDR, ST_READ: begin
        if (hcnt_q != HC_W'(CLK_DIV - 1)) begin
          hcnt_d = hcnt_q + HC_W'(1);
        end else begin
          hcnt_d = '0;
          if (!sclk_q) begin
            // Rising edge: the PROM's bit has been stable for the whole low half.
            sclk_d = 1'b1;
            if (state_q == ST_READ) begin
              rx_d = {rx_q[RD_W-2:0], SPIMISO};
            end
          end else begin
            // Falling edge closes the bit; MOSI moves to the next bit on this same edge.
            sclk_d = 1'b0;
            tx_d   = tx_q << 1;
            mosi_d = tx_q[TX_W-2];
            bit_d  = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              if (last_byte) begin
                byte_d  = '0;
                state_d = next_phase;
              end else begin
                byte_d = byte_q + CNT_W'(1);
              end
            end
          end
        end
      end
      ST_HOLD: begin
        mosi_d = 1'b0;
        if (wait_q == WC_W'(CS_HOLD - 1)) begin
          wait_d  = '0;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + WC_W'(1);
        end
      end
      ST_DONE: begin
        mosi_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Chip select follows the next state so it is a clean registered output.
    cs_n_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_q    <= '0;
      wait_q    <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      len_q     <= '0;
      addr_en_q <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      hcnt_q    <= hcnt_d;
      wait_q    <= wait_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      len_q     <= len_d;
      addr_en_q <= addr_en_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
    end
  end

  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign rd_data   = rx_q;
  assign SPICLK    = sclk_q;
  assign SPIMOSI   = mosi_q;
  assign cs_prom_n = cs_n_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_flash_cmd_engine.sv
// Bench for spi_flash_cmd_engine: PROM response model, transaction-level expectation model
// checked every cycle, and directed RDID/READ/WREN/abort/clamp scenarios.
`timescale 1ns/1ps
module tb_spi_flash_cmd_engine;

  localparam int CLK_DIV      = 2;
  localparam int ADDR_BYTES   = 3;
  localparam int MAX_RD_BYTES = 4;
  localparam int CS_SETUP     = 2;
  localparam int CS_HOLD      = 2;
  localparam int LEN_W        = $clog2(MAX_RD_BYTES + 1);
  localparam int RD_W         = 8 * MAX_RD_BYTES;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        opcode = 8'h00;
  logic              addr_en = 1'b0;
  logic [23:0]       addr = 24'h0;
  logic [LEN_W-1:0]  rd_len = '0;
  logic              SPIMISO = 1'b1;
  logic              busy, done, SPICLK, SPIMOSI, cs_prom_n;
  logic [RD_W-1:0]   rd_data;
  logic [2:0]        state_dbg;

  always #5 clk = ~clk;

  spi_flash_cmd_engine #(
    .CLK_DIV(CLK_DIV), .ADDR_BYTES(ADDR_BYTES), .MAX_RD_BYTES(MAX_RD_BYTES),
    .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode), .addr_en(addr_en),
    .addr(addr), .rd_len(rd_len), .busy(busy), .done(done), .rd_data(rd_data),
    .SPICLK(SPICLK), .SPIMOSI(SPIMOSI), .SPIMISO(SPIMISO), .cs_prom_n(cs_prom_n),
    .state_dbg(state_dbg)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- PROM model ----------------
  logic [7:0] resp [8];
  int         cur_cmd_bits = 8;
  int         rises = 0;
  int         cs_base = 0;
  logic [63:0] mosi_cap = '0;

  always @(posedge SPICLK) begin
    rises++;
    mosi_cap = {mosi_cap[62:0], SPIMOSI};
  end

  always @(negedge cs_prom_n) cs_base = rises;

  always @(negedge SPICLK) begin
    int idx;
    idx = rises - cs_base - cur_cmd_bits;
    if (idx >= 0 && idx < 64) SPIMISO = resp[idx / 8][7 - (idx % 8)];
    else SPIMISO = 1'b1;
  end

  task automatic load_resp(input logic [63:0] v);
    for (int i = 0; i < 8; i++) resp[i] = v[63 - 8*i -: 8];
  endtask

  // ---------------- monitors ----------------
  int done_cnt = 0;
  int busy_cnt = 0;
  int cs_low_cnt = 0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (!cs_prom_n) cs_low_cnt++;
  end

  // ---------------- transaction-level model ----------------
  // m_t counts cycles since the accepting cycle; every output follows from m_t and the
  // latched request through the published timing formula.
  bit              m_active = 1'b0;
  int              m_t = 0;
  int              m_d = 0;
  int              m_b = 0;
  int              m_len = 0;
  logic [31:0]     m_tx = '0;
  logic [RD_W-1:0] m_pk;
  logic [RD_W-1:0] exp_q[$];
  logic [RD_W-1:0] rd_hold = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 1'b0;
      m_t      = 0;
      exp_q.delete();
      rd_hold  = '0;
    end else begin
      if (m_active) begin
        if (m_t == m_d) m_active = 1'b0;
        else m_t++;
      end else if (start) begin
        m_len = (int'(rd_len) > MAX_RD_BYTES) ? MAX_RD_BYTES : int'(rd_len);
        m_tx  = {opcode, addr_en ? addr : 24'h0};
        m_b   = 2 * CLK_DIV * 8 * (1 + (addr_en ? ADDR_BYTES : 0) + m_len);
        m_d   = 1 + CS_SETUP + m_b + CS_HOLD;
        m_pk  = '0;
        for (int i = 0; i < m_len; i++) m_pk = (m_pk << 8) | RD_W'(resp[i]);
        exp_q.push_back(m_pk);
        m_active = 1'b1;
        m_t      = 1;
      end
      if (m_active && m_t == m_d) rd_hold = exp_q.pop_front();
    end
  end

  // ---------------- compare process ----------------
  logic e_busy, e_done, e_cs_n, e_sclk, e_mosi;
  int   e_k, e_bit;

  always @(negedge clk) begin
    e_busy = m_active && (m_t < m_d);
    e_done = m_active && (m_t == m_d);
    e_cs_n = !m_active;
    e_sclk = 1'b0;
    e_mosi = 1'b0;
    if (m_active && m_t >= 1 && m_t <= CS_SETUP) begin
      e_mosi = m_tx[31];
    end else if (m_active && m_t > CS_SETUP && m_t <= CS_SETUP + m_b) begin
      e_k    = m_t - CS_SETUP - 1;
      e_bit  = e_k / (2 * CLK_DIV);
      e_sclk = (e_k % (2 * CLK_DIV)) >= CLK_DIV;
      e_mosi = (e_bit < 32) ? m_tx[31 - e_bit] : 1'b0;
    end
    check("busy", busy, e_busy);
    check("done", done, e_done);
    check("cs_prom_n", cs_prom_n, e_cs_n);
    check("SPICLK", SPICLK, e_sclk);
    check("SPIMOSI", SPIMOSI, e_mosi);
    if (!e_busy) check("rd_data", rd_data, rd_hold);
  end

  // ---------------- driver ----------------
  int b_rises, b_done, b_busy, b_cs;
  int d_cyc;

  // Called at posedge+1: the current cycle becomes the accepting cycle (cycle 0).
  task automatic run_txn(input logic [7:0] op, input logic ae, input logic [23:0] a,
                         input logic [LEN_W-1:0] len, input int g1, input int g2,
                         output int d);
    int cyc;
    bit got;
    cur_cmd_bits = ae ? 8 + 8 * ADDR_BYTES : 8;
    b_rises = rises; b_done = done_cnt; b_busy = busy_cnt; b_cs = cs_low_cnt;
    opcode = op; addr_en = ae; addr = a; rd_len = len; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    got = 1'b0;
    while (!got && cyc < 3000) begin
      start = (cyc == g1) || (cyc == g2);
      if (start) opcode = 8'hC7;
      @(negedge clk);
      if (done) got = 1'b1;
      @(posedge clk); #1;
      if (!got) cyc++;
    end
    start = 1'b0;
    check("done_seen", got, 1'b1);
    d = cyc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    load_resp(64'h0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_rd_data", rd_data, '0);
    check("reset_SPICLK", SPICLK, 1'b0);
    check("reset_SPIMOSI", SPIMOSI, 1'b0);
    check("reset_cs_prom_n", cs_prom_n, 1'b1);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // RDID
    load_resp(64'h2020_1500_0000_0000);
    run_txn(8'h9F, 1'b0, 24'h0, 3'd3, -1, -1, d_cyc);
    check("rdid_rd_data", rd_data, 32'h0020_2015);
    check("rdid_rises", rises - b_rises, 32);
    check("rdid_done_cnt", done_cnt - b_done, 1);
    check("rdid_cycles", d_cyc, 133);
    check("rdid_busy_len", busy_cnt - b_busy, 132);
    check("rdid_mosi", mosi_cap[31:0], 32'h9F00_0000);

    // READ with address
    load_resp(64'hAA55_0FF0_0000_0000);
    run_txn(8'h03, 1'b1, 24'h012345, 3'd4, -1, -1, d_cyc);
    check("read_rd_data", rd_data, 32'hAA55_0FF0);
    check("read_rises", rises - b_rises, 64);
    check("read_cycles", d_cyc, 261);
    check("read_busy_len", busy_cnt - b_busy, 260);
    check("read_mosi", mosi_cap, 64'h0301_2345_0000_0000);

    // WREN: opcode only
    run_txn(8'h06, 1'b0, 24'h0, 3'd0, -1, -1, d_cyc);
    check("wren_rises", rises - b_rises, 8);
    check("wren_cs_low", cs_low_cnt - b_cs, 37);
    check("wren_rd_data", rd_data, 32'h0);
    check("wren_mosi", mosi_cap[7:0], 8'h06);

    // RDID with ignored starts at the busy rise and in the middle of the read phase
    load_resp(64'h2020_1500_0000_0000);
    run_txn(8'h9F, 1'b0, 24'h0, 3'd3, 1, 80, d_cyc);
    check("glitch_done_cnt", done_cnt - b_done, 1);
    check("glitch_rd_data", rd_data, 32'h0020_2015);
    check("glitch_rises", rises - b_rises, 32);
    check("glitch_cycles", d_cyc, 133);
    repeat (4) @(posedge clk);
    #1;
    check("glitch_rd_hold", rd_data, 32'h0020_2015);
    check("glitch_no_extra_done", done_cnt - b_done, 1);

    // Reset during the address phase
    load_resp(64'h1111_1111_0000_0000);
    cur_cmd_bits = 32;
    b_done = done_cnt;
    opcode = 8'h03; addr_en = 1'b1; addr = 24'hABCDEF; rd_len = 3'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (49) @(posedge clk);
    #2;
    check("abort_pre_cs", cs_prom_n, 1'b0);
    check("abort_pre_busy", busy, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check("abort_cs_prom_n", cs_prom_n, 1'b1);
    check("abort_SPICLK", SPICLK, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_rd_data", rd_data, 32'h0);
    repeat (3) @(negedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt - b_done, 0);
    @(posedge clk); #1;
    load_resp(64'hC220_1700_0000_0000);
    run_txn(8'h9F, 1'b0, 24'h0, 3'd3, -1, -1, d_cyc);
    check("post_abort_rd_data", rd_data, 32'h00C2_2017);
    check("post_abort_rises", rises - b_rises, 32);

    // rd_len above MAX is clamped, then a back-to-back start right after done
    load_resp(64'h1122_3344_5566_7788);
    run_txn(8'h9F, 1'b0, 24'h0, 3'd7, -1, -1, d_cyc);
    check("clamp_rd_data", rd_data, 32'h1122_3344);
    check("clamp_rises", rises - b_rises, 40);
    check("clamp_cycles", d_cyc, 165);
    run_txn(8'h06, 1'b0, 24'h0, 3'd0, -1, -1, d_cyc);
    check("b2b_cycles", d_cyc, 37);
    check("b2b_done_cnt", done_cnt - b_done, 1);
    check("b2b_rd_data", rd_data, 32'h0);

    repeat (5) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
